dcache_dm: RTL and testbench
============================

DCACHE_DM -- requirements
Module: dcache_dm

Interface
REQ-001 SHALL have parameter SETS, default 64, number of lines (power of 2, >=2).
REQ-002 SHALL have parameter LINE_BYTES, default 64, line size in bytes (power of 2, 8..64).
REQ-003 SHALL have parameter WORD_BYTES, default 8, CPU word size in bytes (power of 2, <=LINE_BYTES).
REQ-004 SHALL have ports (name, direction, width, meaning):
- clk  in  1  clock; one clock domain, all logic on rising edge.
- reset  in  1  asynchronous reset, active-high.
- enable  in  1  CPU request.
- wen  in  1  1=write, 0=read.
- addr  in  64  byte address, WORD_BYTES-aligned.
- wdata  in  8*WORD_BYTES  write data.
- wstrb  in  WORD_BYTES  byte write enables.
- rdata  out  8*WORD_BYTES  read data.
- done  out  1  one-cycle completion pulse.
- drequest  out  1  memory request.
- dreqack  in  1  memory accepted request.
- dwrenable  out  1  1=line write, 0=line read.
- daddr  out  64  line-aligned memory address.
- drdata  in  8*LINE_BYTES  fill line.
- dwdata  out  8*LINE_BYTES  evict line.
- ddone  in  1  memory transaction complete.

Function
REQ-005 SHALL be direct-mapped, write-back, write-allocate; address split = offset log2(LINE_BYTES), index log2(SETS), tag = the remaining upper bits; per line: valid, dirty, tag, data.
REQ-006 SHALL accept a request only in IDLE with enable=1, capturing addr, wen, wdata and wstrb; enable SHALL be ignored in every other state.
REQ-007 SHALL in simulation call $fatal when an accepted addr is not WORD_BYTES-aligned.
REQ-008 SHALL use states IDLE, EVICT, FILL, RESP.
- IDLE, hit -> RESP.
- IDLE, miss with clean or invalid victim -> FILL.
- IDLE, miss with valid dirty victim -> EVICT.
- EVICT, ddone -> FILL.
- FILL, ddone -> RESP.
- RESP -> IDLE.
REQ-009 SHALL complete a hit with done=1 exactly one cycle after acceptance, for 1-cycle total latency.
REQ-010 SHALL set rdata in the done cycle to the addressed word after any write merge; rdata SHALL be 0 when done=0.
REQ-011 SHALL on a write hit update only the bytes with wstrb=1 and set dirty.
REQ-012 SHALL on entry to EVICT assert drequest=1, dwrenable=1, daddr={victim tag,index,0}, dwdata=victim line.
REQ-013 SHALL on entry to FILL assert drequest=1, dwrenable=0, daddr={tag,index,0}, dwdata=0.
REQ-014 SHALL keep drequest high until the first cycle dreqack=1 is sampled, then drive it low the next cycle; daddr, dwrenable and dwdata SHALL hold stable until ddone.
REQ-015 SHALL accept dreqack and ddone asserted in the same cycle as a complete transaction.
REQ-016 SHALL ignore ddone and dreqack in IDLE and RESP.
REQ-017 SHALL on FILL ddone write drdata into the line, set valid and tag, merge write bytes if wen=1, and set dirty to wen.
REQ-018 SHALL treat a write with wstrb=0 as a write, setting dirty, with no data bytes changed.
REQ-019 SHALL drive done as a one-cycle pulse only in RESP; in the hit path RESP SHALL be entered directly.
REQ-020 SHALL drive drequest, dwrenable, daddr and dwdata to 0 while in IDLE and RESP.

Reset
REQ-021 SHALL on reset asynchronously force state=IDLE, all valid=0, all dirty=0, and done, rdata, drequest, dwrenable, daddr and dwdata to 0.
REQ-022 SHALL on reset mid-EVICT or mid-FILL abandon the transaction with no line state updated; a later ddone SHALL be ignored.
REQ-023 SHALL need no data-array reset; contents of invalid lines are don't-care.

Verification (defaults SETS=64, LINE_BYTES=64, WORD_BYTES=8)
REQ-024 SHALL test cold read miss: after reset, read addr 0x1008; memory returns a line with word1=0xAABB -> one FILL at daddr 0x1000, dwrenable=0; done with rdata=0xAABB; then re-read 0x1008 -> done 1 cycle later, no drequest.
REQ-025 SHALL test write hit and strobes: after REQ-024, write 0x1008, wdata=0x1122334455667788, wstrb=0x0F -> done next cycle; read 0x1008 returns 0x000000005566_7788 | (0xAABB & 0xFFFFFFFF00000000) bytes merged correctly.
REQ-026 SHALL test dirty eviction: after REQ-025, read 0x2008 (same index, new tag) -> EVICT to daddr 0x1000, dwrenable=1, with dwdata holding the merged word; then FILL at 0x2000; done.
REQ-027 SHALL test handshake timing: memory model delays dreqack 3 cycles and ddone 5 cycles, then in another run asserts both in the same cycle -> drequest drops one cycle after dreqack, daddr stays stable until ddone, both runs complete correctly.
REQ-028 SHALL test reset mid-FILL: assert reset 2 cycles into FILL -> outputs 0 immediately; a spurious ddone is ignored; re-reading the address causes a fresh miss.
REQ-029 SHALL test write miss allocate: write 0x3010 to an invalid line -> FILL at 0x3000, no EVICT; the line is left dirty; a later conflicting read evicts it.

Source files
------------

// File: rtl/dcache_dm.sv
// Direct-mapped, write-back, write-allocate data cache with a line-wide
// request/ack/done memory port. Hits complete one cycle after acceptance.
module dcache_dm #(
  parameter int unsigned SETS       = 64,
  parameter int unsigned LINE_BYTES = 64,
  parameter int unsigned WORD_BYTES = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    wen,
  input  logic [63:0]             addr,
  input  logic [8*WORD_BYTES-1:0] wdata,
  input  logic [WORD_BYTES-1:0]   wstrb,
  output logic [8*WORD_BYTES-1:0] rdata,
  output logic                    done,
  output logic                    drequest,
  input  logic                    dreqack,
  output logic                    dwrenable,
  output logic [63:0]             daddr,
  input  logic [8*LINE_BYTES-1:0] drdata,
  output logic [8*LINE_BYTES-1:0] dwdata,
  input  logic                    ddone
);

  localparam int unsigned OFF_W  = $clog2(LINE_BYTES);
  localparam int unsigned IDX_W  = $clog2(SETS);
  localparam int unsigned TAG_W  = 64 - OFF_W - IDX_W;
  localparam int unsigned WORD_W = 8 * WORD_BYTES;
  localparam int unsigned LINE_W = 8 * LINE_BYTES;
  localparam int unsigned BIT_W  = OFF_W + 3;

  typedef enum logic [1:0] {IDLE, EVICT, FILL, RESP} state_t;

  state_t                state_q, state_d;
  logic [63:0]           addr_q, addr_d;
  logic                  wen_q, wen_d;
  logic [WORD_W-1:0]     wdata_q, wdata_d;
  logic [WORD_BYTES-1:0] wstrb_q, wstrb_d;

  logic                  done_q, done_d;
  logic [WORD_W-1:0]     rdata_q, rdata_d;
  logic                  drequest_q, drequest_d;
  logic                  dwrenable_q, dwrenable_d;
  logic [63:0]           daddr_q, daddr_d;
  logic [LINE_W-1:0]     dwdata_q, dwdata_d;

  logic [SETS-1:0]       valid_q, dirty_q;
  logic [TAG_W-1:0]      tag_q  [SETS];
  logic [LINE_W-1:0]     data_q [SETS];

  // Line array write port, driven by the control logic
  logic                  line_we;
  logic [IDX_W-1:0]      line_idx;
  logic [TAG_W-1:0]      line_tag;
  logic                  line_dirty;
  logic [LINE_W-1:0]     line_wdata;

  // Address fields of the incoming request and of the captured one
  logic [TAG_W-1:0]      req_tag, cap_tag;
  logic [IDX_W-1:0]      req_idx, cap_idx;
  logic [OFF_W-1:0]      req_off, cap_off;
  logic                  hit;
  logic [LINE_W-1:0]     merged;

  assign req_tag = addr[63 -: TAG_W];
  assign req_idx = addr[OFF_W +: IDX_W];
  assign req_off = addr[OFF_W-1:0];
  assign cap_tag = addr_q[63 -: TAG_W];
  assign cap_idx = addr_q[OFF_W +: IDX_W];
  assign cap_off = addr_q[OFF_W-1:0];
  assign hit     = valid_q[req_idx] && (tag_q[req_idx] == req_tag);

  function automatic logic [WORD_W-1:0] get_word(input logic [LINE_W-1:0] line,
                                                 input logic [OFF_W-1:0]  off);
    logic [BIT_W-1:0] sh;
    sh = {off, 3'b000};
    return line[sh +: WORD_W];
  endfunction

  function automatic logic [LINE_W-1:0] merge_word(input logic [LINE_W-1:0]     line,
                                                   input logic [OFF_W-1:0]      off,
                                                   input logic [WORD_W-1:0]     data,
                                                   input logic [WORD_BYTES-1:0] strb);
    logic [WORD_W-1:0] m;
    logic [LINE_W-1:0] wm;
    logic [LINE_W-1:0] wd;
    logic [BIT_W-1:0]  sh;
    for (int b = 0; b < int'(WORD_BYTES); b++) m[b*8 +: 8] = {8{strb[b]}};
    sh = {off, 3'b000};
    wm = LINE_W'(m) << sh;
    wd = LINE_W'(data) << sh;
    return (line & ~wm) | (wd & wm);
  endfunction

  // Next-state, memory-port and response logic
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wen_d       = wen_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    done_d      = 1'b0;
    rdata_d     = '0;
    drequest_d  = drequest_q;
    dwrenable_d = dwrenable_q;
    daddr_d     = daddr_q;
    dwdata_d    = dwdata_q;
    line_we     = 1'b0;
    line_idx    = cap_idx;
    line_tag    = cap_tag;
    line_dirty  = 1'b0;
    line_wdata  = '0;
    merged      = '0;

    unique case (state_q)
      IDLE: begin
        drequest_d  = 1'b0;
        dwrenable_d = 1'b0;
        daddr_d     = '0;
        dwdata_d    = '0;
        if (enable) begin
          addr_d  = addr;
          wen_d   = wen;
          wdata_d = wdata;
          wstrb_d = wstrb;
          if (hit) begin
            state_d = RESP;
            done_d  = 1'b1;
            if (wen) begin
              merged     = merge_word(data_q[req_idx], req_off, wdata, wstrb);
              line_we    = 1'b1;
              line_idx   = req_idx;
              line_tag   = req_tag;
              line_dirty = 1'b1;
              line_wdata = merged;
              rdata_d    = get_word(merged, req_off);
            end else begin
              rdata_d = get_word(data_q[req_idx], req_off);
            end
          end else if (valid_q[req_idx] && dirty_q[req_idx]) begin
            state_d     = EVICT;
            drequest_d  = 1'b1;
            dwrenable_d = 1'b1;
            daddr_d     = {tag_q[req_idx], req_idx, {OFF_W{1'b0}}};
            dwdata_d    = data_q[req_idx];
          end else begin
            state_d     = FILL;
            drequest_d  = 1'b1;
            dwrenable_d = 1'b0;
            daddr_d     = {req_tag, req_idx, {OFF_W{1'b0}}};
            dwdata_d    = '0;
          end
        end
      end
      EVICT: begin
        drequest_d = drequest_q & ~dreqack;
        if (ddone) begin
          state_d     = FILL;
          drequest_d  = 1'b1;
          dwrenable_d = 1'b0;
          daddr_d     = {cap_tag, cap_idx, {OFF_W{1'b0}}};
          dwdata_d    = '0;
        end
      end
      FILL: begin
        drequest_d = drequest_q & ~dreqack;
        if (ddone) begin
          merged      = wen_q ? merge_word(drdata, cap_off, wdata_q, wstrb_q) : drdata;
          line_we     = 1'b1;
          line_dirty  = wen_q;
          line_wdata  = merged;
          rdata_d     = get_word(merged, cap_off);
          done_d      = 1'b1;
          state_d     = RESP;
          drequest_d  = 1'b0;
          dwrenable_d = 1'b0;
          daddr_d     = '0;
          dwdata_d    = '0;
        end
      end
      RESP: begin
        state_d     = IDLE;
        drequest_d  = 1'b0;
        dwrenable_d = 1'b0;
        daddr_d     = '0;
        dwdata_d    = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  // Control state, captured request, outputs and line metadata
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      wen_q       <= 1'b0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      done_q      <= 1'b0;
      rdata_q     <= '0;
      drequest_q  <= 1'b0;
      dwrenable_q <= 1'b0;
      daddr_q     <= '0;
      dwdata_q    <= '0;
      valid_q     <= '0;
      dirty_q     <= '0;
    end else begin
      if (state_q == IDLE && enable && ((addr & 64'(WORD_BYTES - 1)) != 64'd0))
        $fatal(1, "dcache_dm: misaligned request address %h", addr);
      state_q     <= state_d;
      addr_q      <= addr_d;
      wen_q       <= wen_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      done_q      <= done_d;
      rdata_q     <= rdata_d;
      drequest_q  <= drequest_d;
      dwrenable_q <= dwrenable_d;
      daddr_q     <= daddr_d;
      dwdata_q    <= dwdata_d;
      if (line_we) begin
        valid_q[line_idx] <= 1'b1;
        dirty_q[line_idx] <= line_dirty;
      end
    end
  end

  // Tag and data arrays; contents of invalid lines are don't-care
  always_ff @(posedge clk) begin
    if (line_we && !reset) begin
      tag_q[line_idx]  <= line_tag;
      data_q[line_idx] <= line_wdata;
    end
  end

  assign done      = done_q;
  assign rdata     = rdata_q;
  assign drequest  = drequest_q;
  assign dwrenable = dwrenable_q;
  assign daddr     = daddr_q;
  assign dwdata    = dwdata_q;

endmodule

// File: tb/tb_dcache_dm.sv
// Directed bench for dcache_dm: hit vectors from a table plus hand-written
// miss, eviction, handshake and reset sequences.
module tb_dcache_dm;

  localparam int unsigned LW = 512;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          enable = 1'b0;
  logic          wen = 1'b0;
  logic [63:0]   addr = '0;
  logic [63:0]   wdata = '0;
  logic [7:0]    wstrb = '0;
  logic [63:0]   rdata;
  logic          done;
  logic          drequest;
  logic          dreqack = 1'b0;
  logic          dwrenable;
  logic [63:0]   daddr;
  logic [LW-1:0] drdata = '0;
  logic [LW-1:0] dwdata;
  logic          ddone = 1'b0;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        wen;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [7:0]  wstrb;
    logic [63:0] exp;
  } vec_t;

  vec_t vt [7];

  logic [LW-1:0] l1, l2, l3, l4, ev1, ev3;

  always #5 clk = ~clk;

  dcache_dm dut (
    .clk(clk), .reset(reset), .enable(enable), .wen(wen), .addr(addr),
    .wdata(wdata), .wstrb(wstrb), .rdata(rdata), .done(done),
    .drequest(drequest), .dreqack(dreqack), .dwrenable(dwrenable),
    .daddr(daddr), .drdata(drdata), .dwdata(dwdata), .ddone(ddone)
  );

  task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [LW-1:0] make_line(input logic [63:0] base);
    logic [LW-1:0] l;
    for (int w = 0; w < 8; w++) l[w*64 +: 64] = base + 64'(w * 8);
    return l;
  endfunction

  // Present one request for a single cycle; returns on the following negedge
  task automatic issue(input logic w, input logic [63:0] a, input logic [63:0] d, input logic [7:0] s);
    @(negedge clk);
    enable = 1'b1; wen = w; addr = a; wdata = d; wstrb = s;
    @(negedge clk);
    enable = 1'b0; wen = 1'b0; wdata = '0; wstrb = '0;
  endtask

  // Memory responder: dreqack after ack_dly cycles, ddone after done_dly cycles
  task automatic mem_serve(input string name, input int ack_dly, input int done_dly,
                           input logic [LW-1:0] line, input logic exp_wr,
                           input logic [63:0] exp_addr, input logic [LW-1:0] exp_wd);
    int t = 0;
    while (drequest !== 1'b1 && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk({name, " drequest"}, LW'(drequest), LW'(1'b1));
    chk({name, " dwdata"}, dwdata, exp_wd);
    for (int k = 0; k <= done_dly; k++) begin
      chk($sformatf("%s drequest@%0d", name, k), LW'(drequest), LW'(k <= ack_dly));
      chk($sformatf("%s daddr@%0d", name, k), LW'(daddr), LW'(exp_addr));
      chk($sformatf("%s dwrenable@%0d", name, k), LW'(dwrenable), LW'(exp_wr));
      dreqack = (k == ack_dly);
      ddone   = (k == done_dly);
      drdata  = line;
      @(negedge clk);
    end
    dreqack = 1'b0;
    ddone   = 1'b0;
    drdata  = '0;
  endtask

  task automatic check_resp(input string name, input logic [63:0] exp);
    chk({name, " done"}, LW'(done), LW'(1'b1));
    chk({name, " rdata"}, LW'(rdata), LW'(exp));
    chk({name, " drequest"}, LW'(drequest), LW'(1'b0));
    @(negedge clk);
    chk({name, " done drop"}, LW'(done), LW'(1'b0));
    chk({name, " rdata idle"}, LW'(rdata), LW'(1'b0));
  endtask

  task automatic check_quiet(input string name);
    chk({name, " done"}, LW'(done), LW'(1'b0));
    chk({name, " rdata"}, LW'(rdata), LW'(1'b0));
    chk({name, " drequest"}, LW'(drequest), LW'(1'b0));
    chk({name, " dwrenable"}, LW'(dwrenable), LW'(1'b0));
    chk({name, " daddr"}, LW'(daddr), LW'(1'b0));
    chk({name, " dwdata"}, dwdata, LW'(1'b0));
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    l1 = make_line(64'h1000);
    l1[64 +: 64] = 64'hAABB;
    l2 = make_line(64'h2000);
    l3 = make_line(64'h3000);
    l4 = make_line(64'h4000);
    ev1 = l1;
    ev1[64 +: 64]  = 64'h0000_0000_5566_7788;
    ev1[448 +: 64] = 64'hDEAD_0000_0000_F00D;
    ev3 = l3;
    ev3[128 +: 64] = 64'h0123_4567_89AB_CDEF;

    vt[0] = '{1'b0, 64'h1008, 64'h0,                   8'h00, 64'hAABB};
    vt[1] = '{1'b1, 64'h1008, 64'h1122_3344_5566_7788, 8'h0F, 64'h0000_0000_5566_7788};
    vt[2] = '{1'b0, 64'h1008, 64'h0,                   8'h00, 64'h0000_0000_5566_7788};
    vt[3] = '{1'b1, 64'h1010, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00, 64'h1010};
    vt[4] = '{1'b1, 64'h1038, 64'hDEAD_BEEF_CAFE_F00D, 8'hC3, 64'hDEAD_0000_0000_F00D};
    vt[5] = '{1'b0, 64'h1000, 64'h0,                   8'h00, 64'h1000};
    vt[6] = '{1'b0, 64'h1038, 64'h0,                   8'h00, 64'hDEAD_0000_0000_F00D};

    // Reset state
    #1 reset = 1'b1;
    #2 check_quiet("reset async");
    @(negedge clk);
    @(negedge clk);
    check_quiet("reset held");
    reset = 1'b0;

    // Cold read miss, fill with dreqack before ddone
    issue(1'b0, 64'h1008, 64'h0, 8'h00);
    chk("cold no done", LW'(done), LW'(1'b0));
    mem_serve("cold fill", 1, 2, l1, 1'b0, 64'h1000, '0);
    check_resp("cold", 64'hAABB);

    // Hits on the resident line
    for (int i = 0; i < 7; i++) begin
      issue(vt[i].wen, vt[i].addr, vt[i].wdata, vt[i].wstrb);
      chk($sformatf("hit%0d done", i), LW'(done), LW'(1'b1));
      chk($sformatf("hit%0d rdata", i), LW'(rdata), LW'(vt[i].exp));
      chk($sformatf("hit%0d drequest", i), LW'(drequest), LW'(1'b0));
      @(negedge clk);
      chk($sformatf("hit%0d done drop", i), LW'(done), LW'(1'b0));
    end

    // Dirty eviction with delayed ack/done, then fill with same-cycle ack/done
    issue(1'b0, 64'h2008, 64'h0, 8'h00);
    mem_serve("evict1", 3, 5, '0, 1'b1, 64'h1000, ev1);
    mem_serve("fill2", 2, 2, l2, 1'b0, 64'h2000, '0);
    check_resp("fill2", 64'h2008);

    // Reset two cycles into a fill; later ddone must be ignored
    issue(1'b0, 64'h4008, 64'h0, 8'h00);
    chk("rst fill drequest", LW'(drequest), LW'(1'b1));
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1 check_quiet("rst midfill");
    @(negedge clk);
    reset = 1'b0;
    ddone  = 1'b1;
    drdata = l4;
    @(negedge clk);
    ddone  = 1'b0;
    drdata = '0;
    check_quiet("spurious ddone");
    issue(1'b0, 64'h4008, 64'h0, 8'h00);
    mem_serve("refill4", 0, 0, l4, 1'b0, 64'h4000, '0);
    check_resp("refill4", 64'h4008);

    // Write miss allocate into an invalid line, then conflicting read evicts it
    do_reset();
    issue(1'b1, 64'h3010, 64'h0123_4567_89AB_CDEF, 8'hFF);
    mem_serve("wfill3", 0, 3, l3, 1'b0, 64'h3000, '0);
    check_resp("wfill3", 64'h0123_4567_89AB_CDEF);
    issue(1'b0, 64'h1008, 64'h0, 8'h00);
    mem_serve("evict3", 1, 1, '0, 1'b1, 64'h3000, ev3);
    mem_serve("fill1b", 0, 0, l1, 1'b0, 64'h1000, '0);
    check_resp("fill1b", 64'hAABB);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
